// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt handler fetch path:
//   - intc_state_t : handler fetch sequencer states
//   - INTC_AW      : handler ROM address width (64 words)
//   - INTC_DW      : instruction width
//   - INTC_ERET    : handler terminator word (MIPS eret)
// -----------------------------------------------------------------------------
package intc_pkg;

  localparam int INTC_AW = 6;
  localparam int INTC_DW = 32;

  localparam logic [INTC_DW-1:0] INTC_ERET = 32'h4200_0018;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } intc_state_t;

endpackage

// File: rtl/intc_handler_fetch.sv
// -----------------------------------------------------------------------------
// intc_handler_fetch
// Reads the interrupt handler program out of the asynchronous handler ROM and
// streams it to the core instruction path over a valid/ready handshake.
// A rising edge on irq starts a run from address 0; the run ends after the
// terminator word (END_WORD) is delivered, or after address 2**AW-1 without a
// terminator (overrun).
//
// Optional feature: define INTC_PENDING_EN to remember one irq edge seen
// during a run and restart straight from DONE without an IDLE cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   irq          in   level interrupt request (edge-detected here)
//   irq_ack      out  one-cycle pulse when a run starts
//   rom_a        out  handler ROM address (combinational from read pointer)
//   rom_y        in   handler ROM data (same-cycle read)
//   instr        out  registered handler instruction
//   instr_valid  out  instr holds an undelivered word
//   instr_ready  in   core accepts instr this cycle
//   busy         out  run in progress (STREAM or DRAIN)
//   done         out  one-cycle pulse after the final word transfers
//   overrun      out  sticky: last run ran off the ROM end without END_WORD
// -----------------------------------------------------------------------------
module intc_handler_fetch
  import intc_pkg::*;
#(
  parameter int              AW       = INTC_AW,
  parameter int              DW       = INTC_DW,
  parameter logic [DW-1:0]   END_WORD = INTC_ERET
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          irq,
  output logic          irq_ack,
  output logic [AW-1:0] rom_a,
  input  logic [DW-1:0] rom_y,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  intc_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          irq_q;
  logic [DW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          irq_ack_q, irq_ack_d;
  logic          overrun_q, overrun_d;
`ifdef INTC_PENDING_EN
  logic          pending_q, pending_d;
`endif

  logic irq_rise;
  logic load_ok;
  logic xfer;

  assign irq_rise = irq & ~irq_q;
  // Output register may take a new word when empty or being emptied this cycle.
  assign load_ok  = ~instr_valid_q | instr_ready;
  assign xfer     = instr_valid_q & instr_ready;

  // Stage p0: next-state and datapath selection
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    irq_ack_d     = 1'b0;
    overrun_d     = overrun_q;
`ifdef INTC_PENDING_EN
    pending_d     = pending_q;
`endif

    case (state_q)
      ST_IDLE: begin
        ptr_d = '0;
        if (irq_rise) begin
          state_d   = ST_STREAM;
          irq_ack_d = 1'b1;
          overrun_d = 1'b0;
        end
      end

      ST_STREAM: begin
`ifdef INTC_PENDING_EN
        if (irq_rise) pending_d = 1'b1;
`endif
        if (xfer) instr_valid_d = 1'b0;
        if (load_ok) begin
          instr_d       = rom_y;
          instr_valid_d = 1'b1;
          // Pointer saturates at the last address so it never wraps to 0.
          if (ptr_q != PTR_LAST) ptr_d = ptr_q + 1'b1;
          if (rom_y == END_WORD) begin
            state_d = ST_DRAIN;
          end else if (ptr_q == PTR_LAST) begin
            state_d   = ST_DRAIN;
            overrun_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
`ifdef INTC_PENDING_EN
        if (irq_rise) pending_d = 1'b1;
`endif
        if (xfer) begin
          instr_valid_d = 1'b0;
          ptr_d         = '0;
          state_d       = ST_DONE;
        end
      end

      ST_DONE: begin
        ptr_d   = '0;
        state_d = ST_IDLE;
`ifdef INTC_PENDING_EN
        // An edge arriving in DONE itself is folded into the same restart.
        if (pending_q | irq_rise) begin
          pending_d = 1'b0;
          irq_ack_d = 1'b1;
          overrun_d = 1'b0;
          state_d   = ST_STREAM;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: registered state, pointer and output word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      irq_q         <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      irq_ack_q     <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef INTC_PENDING_EN
      pending_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      irq_q         <= irq;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      irq_ack_q     <= irq_ack_d;
      overrun_q     <= overrun_d;
`ifdef INTC_PENDING_EN
      pending_q     <= pending_d;
`endif
    end
  end

  assign rom_a       = ptr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign irq_ack     = irq_ack_q;
  assign busy        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_intc_handler_fetch.sv
// -----------------------------------------------------------------------------
// tb_intc_handler_fetch
// Directed bench for intc_handler_fetch with a behavioural asynchronous
// handler ROM. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_intc_handler_fetch;

  logic        clk;
  logic        rst_n;
  logic        irq;
  logic        irq_ack;
  logic [5:0]  rom_a;
  logic [31:0] rom_y;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [31:0] rom [64];
  assign rom_y = rom[rom_a];

  int n_vec;
  int n_err;

  // Observation accumulators filled by watch()
  int          acks;
  int          dones;
  int          nwords;
  logic [31:0] words [128];

  intc_handler_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .rom_a       (rom_a),
    .rom_y       (rom_y),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
    rom[0] = 32'h2008_0001;
    rom[1] = 32'h2009_0002;
    rom[2] = 32'h4200_0018;
  endtask

  task automatic clr_watch();
    acks   = 0;
    dones  = 0;
    nwords = 0;
  endtask

  // Sample the current cycle, then advance; repeat ncyc times.
  task automatic watch(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (irq_ack) acks++;
      if (done) dones++;
      if (instr_valid && instr_ready) begin
        if (nwords < 128) words[nwords] = instr;
        nwords++;
      end
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    irq = 1'b0;
    instr_ready = 1'b1;
    load_basic();

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd0);
    chk("rst_ack",     {31'd0, irq_ack},     32'd0);
    chk("rst_done",    {31'd0, done},        32'd0);
    chk("rst_overrun", {31'd0, overrun},     32'd0);
    chk("rst_rom_a",   {26'd0, rom_a},       32'd0);
    chk("rst_instr",   instr,                32'd0);

    // Basic run, cycle-exact
    irq = 1'b1;
    tick();
    chk("b_ack1",   {31'd0, irq_ack}, 32'd1);
    chk("b_busy1",  {31'd0, busy},    32'd1);
    chk("b_valid1", {31'd0, instr_valid}, 32'd0);
    chk("b_rom_a1", {26'd0, rom_a},   32'd0);
    tick();
    chk("b_valid2", {31'd0, instr_valid}, 32'd1);
    chk("b_w0",     instr,            32'h2008_0001);
    chk("b_ack2",   {31'd0, irq_ack}, 32'd0);
    tick();
    chk("b_w1",     instr,            32'h2009_0002);
    tick();
    chk("b_w2",     instr,            32'h4200_0018);
    chk("b_busy4",  {31'd0, busy},    32'd1);
    tick();
    chk("b_done5",  {31'd0, done},    32'd1);
    chk("b_busy5",  {31'd0, busy},    32'd0);
    chk("b_valid5", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("b_done6",  {31'd0, done},    32'd0);
    chk("b_busy6",  {31'd0, busy},    32'd0);
    irq = 1'b0;
    tick(); tick();

    // Backpressure
    irq = 1'b1;
    tick();
    tick();
    chk("bp_first", instr, 32'h2008_0001);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_instr", instr,                32'h2008_0001);
      chk("bp_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_hold_rom_a", {26'd0, rom_a},       32'd1);
    end
    instr_ready = 1'b1;
    clr_watch();
    watch(8);
    chk("bp_nwords", nwords,   32'd3);
    chk("bp_w0",     words[0], 32'h2008_0001);
    chk("bp_w1",     words[1], 32'h2009_0002);
    chk("bp_w2",     words[2], 32'h4200_0018);
    chk("bp_done",   dones,    32'd1);
    irq = 1'b0;
    tick(); tick();

    // Overrun: no terminator anywhere
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
    irq = 1'b1;
    clr_watch();
    watch(70);
    chk("ov_nwords", nwords,    32'd64);
    chk("ov_w0",     words[0],  32'h1000_0000);
    chk("ov_w63",    words[63], 32'h1000_003f);
    chk("ov_acks",   acks,      32'd1);
    chk("ov_dones",  dones,     32'd1);
    chk("ov_flag",   {31'd0, overrun}, 32'd1);
    irq = 1'b0;
    tick(); tick(); tick();
    chk("ov_sticky", {31'd0, overrun}, 32'd1);

    // Next run clears overrun; then reset during word 2
    load_basic();
    irq = 1'b1;
    tick();
    chk("rm_ack",     {31'd0, irq_ack}, 32'd1);
    chk("ov_cleared", {31'd0, overrun}, 32'd0);
    tick();
    tick();
    chk("rm_w1", instr, 32'h2009_0002);
    rst_n = 1'b0;
    irq = 1'b0;
    tick();
    chk("rm_valid", {31'd0, instr_valid}, 32'd0);
    chk("rm_busy",  {31'd0, busy},        32'd0);
    chk("rm_rom_a", {26'd0, rom_a},       32'd0);
    chk("rm_instr", instr,                32'd0);
    rst_n = 1'b1;
    tick();
    irq = 1'b1;
    clr_watch();
    watch(8);
    chk("rm_restart_n",  nwords,   32'd3);
    chk("rm_restart_w0", words[0], 32'h2008_0001);
    irq = 1'b0;
    tick(); tick();

    // Second irq edge while busy
    clr_watch();
    irq = 1'b1;
    watch(3);
    irq = 1'b0;
    watch(1);
    irq = 1'b1;
    watch(15);
`ifdef INTC_PENDING_EN
    chk("ir_acks",   acks,     32'd2);
    chk("ir_dones",  dones,    32'd2);
    chk("ir_nwords", nwords,   32'd6);
    chk("ir_replay", words[3], 32'h2008_0001);
`else
    chk("ir_acks",   acks,     32'd1);
    chk("ir_dones",  dones,    32'd1);
    chk("ir_nwords", nwords,   32'd3);
`endif
    irq = 1'b0;
    tick(); tick(); tick();

    // Level irq held high for 20 cycles
    clr_watch();
    irq = 1'b1;
    watch(20);
    irq = 1'b0;
    watch(4);
    chk("lv_acks",   acks,   32'd1);
    chk("lv_dones",  dones,  32'd1);
    chk("lv_nwords", nwords, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
